ps_requester: RTL



---
 rtl/ps_requester.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ps_requester.sv
// Requester-side controller for an N-way priority selector: collects request
// pulses, arbitrates through the selector, runs a fixed service window per grant.
module ps_requester #(
    parameter int N        = 8,
    parameter int HOLD     = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] new_req,
    input  logic [N-1:0] gnt,
    output logic [N-1:0] req,
    output logic         en,
    output logic         busy,
    output logic [N-1:0] served,
    output logic [N-1:0] starve,
    output logic [7:0]   grant_count,
    output logic         err
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [3:0] AGE_MAX = 4'(WAIT_MAX);

    typedef enum logic [1:0] {IDLE, ARB, SERVE} state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  pending;
    logic [N-1:0]  owner;
    logic [N-1:0]  retire;
    logic [CW-1:0] cnt;
    logic [3:0]    age [N];
    logic          gnt_onehot;
    logic          gnt_legal;
    logic          gnt_illegal;
    logic          serve_last;

    // A grant is only accepted in ARB, one-hot, and only for a pending client;
    // any other non-zero grant is a protocol error.
    always_comb begin
        gnt_onehot  = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
        gnt_legal   = (state == ARB) && gnt_onehot && ((gnt & ~pending) == '0);
        gnt_illegal = (gnt != '0) && !gnt_legal;
        serve_last  = (state == SERVE) && (cnt == '0);
        retire      = serve_last ? owner : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending != '0) state_next = ARB;
            ARB:     if (gnt_legal) state_next = SERVE;
            SERVE: begin
                if (serve_last) begin
                    state_next = ((pending & ~owner) != '0) ? ARB : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        en   = (state == ARB);
        busy = (state == SERVE);
        req  = pending;
    end

    // A new_req on the retiring bit wins, so the bit stays set.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending     <= '0;
            owner       <= '0;
            cnt         <= '0;
            served      <= '0;
            grant_count <= '0;
            err         <= 1'b0;
        end else begin
            pending <= (pending & ~retire) | new_req;
            served  <= retire;
            if (gnt_legal) begin
                owner       <= gnt;
                grant_count <= grant_count + 8'd1;
                cnt         <= CW'(HOLD - 1);
            end else if ((state == SERVE) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (gnt_illegal) begin
                err <= 1'b1;
            end
        end
    end

    // Ages count only while waiting; the client being served does not age.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (retire[i] || (gnt_legal && gnt[i])) begin
                    age[i] <= '0;
                end else if (pending[i] && !((state == SERVE) && owner[i]) &&
                             (age[i] < AGE_MAX)) begin
                    age[i] <= age[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < N; i++) begin
            starve[i] = (age[i] >= AGE_MAX);
        end
    end

endmodule
